// File: rtl/mem_axi_read_burst_ctrl_if.sv
// AXI4 read-address channel plus the observed R handshake signals
// for the read burst scheduler.
interface mem_axi_read_burst_ctrl_if #(
    parameter int unsigned C_ADDR_WIDTH = 64
);
    logic                    arvalid;
    logic                    arready;
    logic [C_ADDR_WIDTH-1:0] araddr;
    logic [7:0]              arlen;
    logic                    rvalid;
    logic                    rready;
    logic                    rlast;

    modport master (
        output arvalid,
        output araddr,
        output arlen,
        input  arready,
        input  rvalid,
        input  rready,
        input  rlast
    );

    modport slave (
        input  arvalid,
        input  araddr,
        input  arlen,
        output arready,
        output rvalid,
        output rready,
        output rlast
    );
endinterface

// File: rtl/mem_axi_read_burst_ctrl.sv
// AXI4 read-address scheduler: splits a byte-sized transfer into fixed-length INCR
// bursts and caps the number of bursts in flight (AR handshakes up, R last beats down).
module mem_axi_read_burst_ctrl #(
    parameter int unsigned C_ADDR_WIDTH      = 64,
    parameter int unsigned C_DATA_WIDTH      = 512,
    parameter int unsigned C_XFER_SIZE_WIDTH = 32,
    parameter int unsigned C_BURST_LEN       = 64,
    parameter int unsigned C_MAX_OUTSTANDING = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_ctrl_start,
    input  logic [C_ADDR_WIDTH-1:0]      i_ctrl_addr_offset,
    input  logic [C_XFER_SIZE_WIDTH-1:0] i_ctrl_xfer_size_in_bytes,
    output logic                         o_ctrl_busy,
    output logic                         o_ctrl_done,
    mem_axi_read_burst_ctrl_if.master    m_axi
);
    localparam int unsigned BB      = C_DATA_WIDTH / 8;
    localparam int unsigned BB_LOG2 = $clog2(BB);
    localparam int unsigned XSW     = C_XFER_SIZE_WIDTH;
    localparam int unsigned CNT_W   = $clog2(C_MAX_OUTSTANDING + 1);
    localparam logic [C_ADDR_WIDTH-1:0] BURST_BYTES = C_ADDR_WIDTH'(C_BURST_LEN * BB);
    localparam logic [7:0]              FULL_LEN    = 8'(C_BURST_LEN - 1);
    localparam logic [XSW-1:0]          BL_X        = XSW'(C_BURST_LEN);
    localparam logic [CNT_W-1:0]        MAX_CNT     = CNT_W'(C_MAX_OUTSTANDING);

    typedef enum logic [1:0] {StIdle, StCalc, StIssue, StDrain} state_t;

    state_t                  r_state, w_state_nxt;
    logic [C_ADDR_WIDTH-1:0] r_addr, w_addr_nxt;
    logic [XSW-1:0]          r_size, w_size_nxt;
    logic [XSW-1:0]          r_bursts_left, w_bursts_left_nxt;
    logic [7:0]              r_last_len, w_last_len_nxt;
    logic [7:0]              r_arlen, w_arlen_nxt;
    logic                    r_arvalid, w_arvalid_nxt;
    logic                    r_done, w_done_nxt;
    logic [CNT_W-1:0]        r_outstanding, w_outstanding_nxt;

    logic                    w_ar_hs;
    logic                    w_rl_hs;
    logic                    w_cap_ok;
    logic [XSW-1:0]          w_beats;
    logic [XSW-1:0]          w_rem;
    logic [XSW-1:0]          w_bursts;
    logic [7:0]              w_calc_last_len;

    assign w_ar_hs = r_arvalid & m_axi.arready;
    assign w_rl_hs = m_axi.rvalid & m_axi.rready & m_axi.rlast;

    // Shift-and-round-up avoids the overflow of size+BB-1 at full width.
    assign w_beats = (r_size >> BB_LOG2) + XSW'(r_size[BB_LOG2-1:0] != '0);
    assign w_rem   = w_beats % BL_X;
    assign w_bursts = (w_beats / BL_X) + XSW'(w_rem != '0);
    assign w_calc_last_len = (w_rem == '0) ? FULL_LEN : 8'(w_rem - XSW'(1));

    always_comb begin
        w_outstanding_nxt = r_outstanding;
        if (w_ar_hs && !w_rl_hs) begin
            w_outstanding_nxt = r_outstanding + CNT_W'(1);
        end else if (!w_ar_hs && w_rl_hs && (r_outstanding != '0)) begin
            w_outstanding_nxt = r_outstanding - CNT_W'(1);
        end
    end

    // Gating on the next count keeps the cap intact for back-to-back bursts.
    assign w_cap_ok = (w_outstanding_nxt < MAX_CNT);

    always_comb begin
        w_state_nxt       = r_state;
        w_addr_nxt        = r_addr;
        w_size_nxt        = r_size;
        w_bursts_left_nxt = r_bursts_left;
        w_last_len_nxt    = r_last_len;
        w_arlen_nxt       = r_arlen;
        w_arvalid_nxt     = r_arvalid;
        w_done_nxt        = 1'b0;
        unique case (r_state)
            StIdle: begin
                // A start coinciding with the done pulse is dropped.
                if (i_ctrl_start && !r_done) begin
                    w_state_nxt = StCalc;
                    w_addr_nxt  = i_ctrl_addr_offset;
                    w_size_nxt  = i_ctrl_xfer_size_in_bytes;
                end
            end
            StCalc: begin
                w_bursts_left_nxt = w_bursts;
                w_last_len_nxt    = w_calc_last_len;
                if (w_bursts == '0) begin
                    w_state_nxt = StDrain;
                end else begin
                    w_state_nxt   = StIssue;
                    w_arvalid_nxt = w_cap_ok;
                    w_arlen_nxt   = (w_bursts == XSW'(1)) ? w_calc_last_len : FULL_LEN;
                end
            end
            StIssue: begin
                if (w_ar_hs) begin
                    w_addr_nxt        = r_addr + BURST_BYTES;
                    w_bursts_left_nxt = r_bursts_left - XSW'(1);
                    if (r_bursts_left == XSW'(1)) begin
                        w_arvalid_nxt = 1'b0;
                        w_state_nxt   = StDrain;
                    end else begin
                        w_arvalid_nxt = w_cap_ok;
                        w_arlen_nxt   = (r_bursts_left == XSW'(2)) ? r_last_len : FULL_LEN;
                    end
                end else if (!r_arvalid) begin
                    w_arvalid_nxt = w_cap_ok;
                end
            end
            StDrain: begin
                if (r_outstanding == '0) begin
                    w_done_nxt  = 1'b1;
                    w_state_nxt = StIdle;
                end
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= StIdle;
            r_addr        <= '0;
            r_size        <= '0;
            r_bursts_left <= '0;
            r_last_len    <= '0;
            r_arlen       <= '0;
            r_arvalid     <= 1'b0;
            r_done        <= 1'b0;
            r_outstanding <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_addr        <= w_addr_nxt;
            r_size        <= w_size_nxt;
            r_bursts_left <= w_bursts_left_nxt;
            r_last_len    <= w_last_len_nxt;
            r_arlen       <= w_arlen_nxt;
            r_arvalid     <= w_arvalid_nxt;
            r_done        <= w_done_nxt;
            r_outstanding <= w_outstanding_nxt;
        end
    end

    assign o_ctrl_busy   = (r_state != StIdle);
    assign o_ctrl_done   = r_done;
    assign m_axi.arvalid = r_arvalid;
    assign m_axi.araddr  = r_addr;
    assign m_axi.arlen   = r_arlen;
endmodule

// File: tb/tb_mem_axi_read_burst_ctrl.sv
// Directed bench for mem_axi_read_burst_ctrl: AR scoreboard fed from a burst model,
// AR stability monitor, and cycle-exact control/latency checks.
module tb_mem_axi_read_burst_ctrl;
    localparam int unsigned AW   = 64;
    localparam int unsigned XSW  = 32;
    localparam int unsigned BB   = 64;
    localparam int unsigned BL   = 64;
    localparam int unsigned MAXO = 2;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic [AW-1:0]  offset;
    logic [XSW-1:0] size;
    logic           busy;
    logic           done;

    always #5 clk = ~clk;

    mem_axi_read_burst_ctrl_if #(.C_ADDR_WIDTH(AW)) u_if ();

    mem_axi_read_burst_ctrl #(
        .C_ADDR_WIDTH     (AW),
        .C_DATA_WIDTH     (BB * 8),
        .C_XFER_SIZE_WIDTH(XSW),
        .C_BURST_LEN      (BL),
        .C_MAX_OUTSTANDING(MAXO)
    ) u_dut (
        .clk                      (clk),
        .rst                      (rst),
        .i_ctrl_start             (start),
        .i_ctrl_addr_offset       (offset),
        .i_ctrl_xfer_size_in_bytes(size),
        .o_ctrl_busy              (busy),
        .o_ctrl_done              (done),
        .m_axi                    (u_if)
    );

    typedef struct {
        logic [63:0] addr;
        logic [7:0]  len;
    } ar_t;

    ar_t exp_q[$];
    int  n_checks = 0;
    int  n_errors = 0;
    int  n_hs     = 0;
    int  n_rl     = 0;
    int  n_done   = 0;
    int  n_av     = 0;

    function automatic void chk(string tag, logic [63:0] obs, logic [63:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endfunction

    function automatic void push_model(logic [63:0] a, logic [31:0] s);
        longint unsigned beats, bursts, rem;
        ar_t e;
        beats  = (64'(s) + BB - 1) / BB;
        bursts = (beats + BL - 1) / BL;
        rem    = beats % BL;
        for (longint unsigned k = 0; k < bursts; k++) begin
            e.addr = a + k * BB * BL;
            e.len  = ((k == bursts - 1) && (rem != 0)) ? 8'(rem - 1) : 8'(BL - 1);
            exp_q.push_back(e);
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_r(logic v);
        u_if.rvalid = v;
        u_if.rready = v;
        u_if.rlast  = v;
    endtask

    task automatic pulse_start(logic [63:0] a, logic [31:0] s);
        offset = a;
        size   = s;
        push_model(a, s);
        start  = 1'b1;
        tick();
        start  = 1'b0;
    endtask

    // Answers every accepted burst with one rlast beat until ctrl_done, bounded.
    task automatic finish_xfer(string tag);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 600 && !seen; i++) begin
            if (done) begin
                seen = 1'b1;
            end else if (!u_if.rlast && (n_hs > n_rl)) begin
                set_r(1'b1);
                n_rl++;
            end else begin
                set_r(1'b0);
            end
            if (!seen) tick();
        end
        set_r(1'b0);
        chk({tag, "_done"}, 64'(seen), 1);
        chk({tag, "_busy_low_at_done"}, 64'(busy), 0);
        chk({tag, "_sb_empty"}, 64'(exp_q.size()), 0);
        tick();
    endtask

    // AR monitor: scoreboard pop on handshake, stability while stalled.
    initial begin
        logic        prev_stall;
        logic [63:0] prev_addr;
        logic [7:0]  prev_len;
        ar_t         e;
        prev_stall = 1'b0;
        prev_addr  = '0;
        prev_len   = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_stall = 1'b0;
            end else begin
                if (u_if.arvalid) n_av++;
                if (done) n_done++;
                if (prev_stall) begin
                    chk("ar_hold_valid", 64'(u_if.arvalid), 1);
                    chk("ar_hold_addr", u_if.araddr, prev_addr);
                    chk("ar_hold_len", 64'(u_if.arlen), 64'(prev_len));
                end
                if (u_if.arvalid && u_if.arready) begin
                    n_hs++;
                    chk("ar_expected_pending", 64'(exp_q.size() != 0), 1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        chk("ar_addr", u_if.araddr, e.addr);
                        chk("ar_len", 64'(u_if.arlen), 64'(e.len));
                    end
                end
                prev_stall = u_if.arvalid && !u_if.arready;
                prev_addr  = u_if.araddr;
                prev_len   = u_if.arlen;
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base_hs, base_done, base_av;
        rst = 1'b1;
        start = 1'b0;
        offset = '0;
        size = '0;
        u_if.arready = 1'b0;
        set_r(1'b0);
        repeat (2) tick();
        chk("rst_arvalid", 64'(u_if.arvalid), 0);
        chk("rst_araddr", u_if.araddr, 0);
        chk("rst_arlen", 64'(u_if.arlen), 0);
        chk("rst_busy", 64'(busy), 0);
        chk("rst_done", 64'(done), 0);
        rst = 1'b0;
        tick();

        // T1: two full bursts, done two cycles after the second rlast.
        u_if.arready = 1'b1;
        base_hs = n_hs;
        base_done = n_done;
        pulse_start(64'h1000, 32'd8192);
        chk("t1_busy_c1", 64'(busy), 1);
        chk("t1_arvalid_c1", 64'(u_if.arvalid), 0);
        tick();
        chk("t1_arvalid_c2", 64'(u_if.arvalid), 1);
        chk("t1_araddr_c2", u_if.araddr, 64'h1000);
        repeat (8) tick();
        chk("t1_two_ars", 64'(n_hs - base_hs), 2);
        chk("t1_no_done_yet", 64'(n_done - base_done), 0);
        chk("t1_busy_wait", 64'(busy), 1);
        set_r(1'b1);
        n_rl++;
        tick();
        set_r(1'b0);
        tick();
        chk("t1_done_after_one", 64'(done), 0);
        set_r(1'b1);
        n_rl++;
        tick();
        set_r(1'b0);
        chk("t1_done_not_early", 64'(done), 0);
        tick();
        chk("t1_done_two_after", 64'(done), 1);
        chk("t1_busy_at_done", 64'(busy), 0);
        tick();
        chk("t1_done_pulse", 64'(done), 0);

        // T2: partial last bursts.
        pulse_start(64'h4000, 32'd100);
        finish_xfer("t2_100");
        pulse_start(64'h5000, 32'd64);
        finish_xfer("t2_64");
        pulse_start(64'h6000, 32'd4097);
        finish_xfer("t2_4097");

        // T3: zero size, plus start on the done cycle vs the cycle after.
        base_av = n_av;
        base_hs = n_hs;
        pulse_start(64'h7000, 32'd0);
        chk("t3_busy_c1", 64'(busy), 1);
        chk("t3_done_c1", 64'(done), 0);
        tick();
        chk("t3_busy_c2", 64'(busy), 1);
        chk("t3_done_c2", 64'(done), 0);
        tick();
        chk("t3_done_c3", 64'(done), 1);
        chk("t3_busy_c3", 64'(busy), 0);
        start = 1'b1;
        tick();
        chk("t3_start_on_done_ignored", 64'(busy), 0);
        tick();
        start = 1'b0;
        chk("t3_start_after_done_taken", 64'(busy), 1);
        tick();
        tick();
        chk("t3_second_done", 64'(done), 1);
        tick();
        chk("t3_no_arvalid", 64'(n_av - base_av), 0);
        chk("t3_no_ar_hs", 64'(n_hs - base_hs), 0);

        // T4: cap of two bursts in flight.
        base_hs = n_hs;
        pulse_start(64'h10000, 32'd20480);
        repeat (8) tick();
        chk("t4_cap_two", 64'(n_hs - base_hs), 2);
        chk("t4_cap_arvalid_low", 64'(u_if.arvalid), 0);
        set_r(1'b1);
        n_rl++;
        tick();
        set_r(1'b0);
        repeat (4) tick();
        chk("t4_release_one", 64'(n_hs - base_hs), 3);
        chk("t4_low_again", 64'(u_if.arvalid), 0);
        u_if.arready = 1'b0;
        set_r(1'b1);
        n_rl++;
        tick();
        set_r(1'b0);
        tick();
        chk("t4_stalled_valid", 64'(u_if.arvalid), 1);
        chk("t4_stalled_count", 64'(n_hs - base_hs), 3);
        u_if.arready = 1'b1;
        set_r(1'b1);
        n_rl++;
        tick();
        set_r(1'b0);
        repeat (4) tick();
        chk("t4_simul_no_change", 64'(n_hs - base_hs), 5);
        finish_xfer("t4");

        // T5: long arready stall with ignored starts.
        u_if.arready = 1'b0;
        pulse_start(64'h20000, 32'd8192);
        tick();
        for (int i = 0; i < 10; i++) begin
            chk("t5_stall_valid", 64'(u_if.arvalid), 1);
            chk("t5_stall_addr", u_if.araddr, 64'h20000);
            chk("t5_stall_len", 64'(u_if.arlen), 63);
            if (i == 3) begin
                offset = 64'h90000;
                size   = 32'd64;
                start  = 1'b1;
            end else begin
                start = 1'b0;
            end
            tick();
        end
        start = 1'b0;
        u_if.arready = 1'b1;
        finish_xfer("t5");

        // T6: asynchronous abort after the first of four bursts, then a clean rerun.
        base_hs = n_hs;
        base_done = n_done;
        pulse_start(64'h30000, 32'd16384);
        tick();
        tick();
        chk("t6_one_ar_before_rst", 64'(n_hs - base_hs), 1);
        rst = 1'b1;
        #1;
        chk("t6_rst_arvalid", 64'(u_if.arvalid), 0);
        chk("t6_rst_araddr", u_if.araddr, 0);
        chk("t6_rst_arlen", 64'(u_if.arlen), 0);
        chk("t6_rst_busy", 64'(busy), 0);
        chk("t6_rst_done", 64'(done), 0);
        exp_q.delete();
        n_rl = n_hs;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        chk("t6_no_done", 64'(n_done - base_done), 0);
        pulse_start(64'h40000, 32'd16384);
        tick();
        chk("t6_rerun_valid", 64'(u_if.arvalid), 1);
        chk("t6_rerun_addr", u_if.araddr, 64'h40000);
        chk("t6_rerun_len", 64'(u_if.arlen), 63);
        finish_xfer("t6_rerun");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
